axis_decimator_scheduler: RTL and testbench
===========================================

# axis_decimator_scheduler

- Sequences an `axis_decimator` through up to NSEG acquisition segments.
- Each segment has its own decimation ratio and its own output-sample count.
- The block drives the decimator's reset and `cfg_data`, gates the decimator's output stream, marks segment ends with `tlast` and tags every beat with its segment index.
- It sits between the decimator master port and the downstream DMA/FIFO and is configured from the PS register bank.

## Interface

- `CNTR_WIDTH`, 32, width of decimator ratio (`cfg_data` of decimator)
- `SMPL_WIDTH`, 32, width of per-segment output-sample count
- `AXIS_TDATA_WIDTH`, 32, stream data width
- `NSEG`, 4, number of segment table entries (2..16)
- `LOAD_CYCLES`, 2, cycles the decimator is held in reset per segment load (>=1)
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low; clock aclk
- cfg_enable  in  1  level; rising edge starts sequence at segment 0; low aborts
- cfg_loop  in  1  restart at segment 0 after last segment
- cfg_nseg  in  $clog2(NSEG)+1  number of active segments
- cfg_ratio  in  NSEG*CNTR_WIDTH  packed ratios, segment k at bits [k*CNTR_WIDTH +: CNTR_WIDTH]
- cfg_count  in  NSEG*SMPL_WIDTH  packed output counts, same packing
- dec_aresetn  out  1  reset to decimator, active-low
- dec_cfg_data  out  CNTR_WIDTH  ratio to decimator
- s_axis_tdata/tvalid  in  AXIS_TDATA_WIDTH/1  from decimator master
- s_axis_tready  out  1  to decimator
- m_axis_tdata/tvalid/tlast  out  AXIS_TDATA_WIDTH/1/1  downstream stream
- m_axis_tuser  out  $clog2(NSEG)  segment index of current beat
- m_axis_tready  in  1
- sts_busy  out  1  state != IDLE
- sts_segment  out  $clog2(NSEG)  current segment index
- sts_done  out  1  one-cycle pulse when a non-looping sequence completes

## Operation

- **States:** IDLE, LOAD, RUN.
- **IDLE:**
  - `dec_aresetn`=0; `s_axis_tready`=`m_axis_tvalid`=0.
  - A rising edge of `cfg_enable` (registered previous value) with `cfg_nseg`!=0 starts the sequence: seg=0, then LOAD.
- **LOAD:**
  - On entry, `dec_cfg_data` is registered to `cfg_ratio[seg]`, `dec_aresetn`=0 and the load counter is cleared.
  - After LOAD_CYCLES cycles the block enters RUN with `dec_aresetn`=1.
  - A segment with `cfg_count[seg]`==0 is skipped: LOAD advances directly to the next segment. The segment still costs LOAD_CYCLES.
- **RUN:** combinational pass-through.
  - `m_axis_tvalid` = `s_axis_tvalid`.
  - `s_axis_tready` = `m_axis_tready`.
  - `m_axis_tdata` = `s_axis_tdata`.
  - `m_axis_tuser` = seg.
- **Beat counting:**
  - The beat counter (SMPL_WIDTH) increments on each handshake (`s_axis_tvalid & m_axis_tready`).
  - `m_axis_tlast` = (beat counter == `cfg_count[seg]`-1).
  - A handshake with tlast clears the counter and ends the segment.
- **Segment end:**
  - If seg+1 < min(`cfg_nseg`, NSEG): seg++ and go to LOAD.
  - Else, if `cfg_loop`: seg=0 and go to LOAD.
  - Else: pulse `sts_done` and go to IDLE.
- **Configuration sampling:**
  - `cfg_nseg` > NSEG is clamped to NSEG.
  - `cfg_ratio`/`cfg_count` are sampled per segment: the ratio on LOAD entry, the count continuously during RUN. Software changes them only while IDLE.
- **Abort:**
  - `cfg_enable` low in any state sends the block to IDLE on the next cycle. The counters are cleared, `dec_aresetn` drops and no `sts_done` pulse is generated.
  - A beat presented during the abort cycle may be withdrawn. This is the only permitted AXIS tvalid drop.
- **Ratio semantics:** the decimator emits one output per ratio+1 accepted inputs. The scheduler does not check this.

## Timing

- **Reset values:**
  - `dec_aresetn`=0, `dec_cfg_data`=0.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `s_axis_tready`=0.
  - `sts_busy`=0, `sts_segment`=0, `sts_done`=0.
  - State IDLE; the previous-`cfg_enable` register is cleared, so `cfg_enable` held high through reset starts a sequence one cycle after reset release.
- **Start:** a rising edge sampled at cycle n gives LOAD in cycles n+1..n+LOAD_CYCLES and RUN from n+LOAD_CYCLES+1.
- **Segment change:** the tlast handshake at cycle m gives LOAD from m+1; the next RUN starts at m+1+LOAD_CYCLES. Data in the decimator at the switch is discarded by its reset.
- **Stream path:** zero-latency pass-through; `s_axis_tready`/`m_axis_tvalid` are never asserted outside RUN.
- **`sts_done`:** asserted in the cycle after the final tlast handshake, concurrent with the IDLE entry.
- **Counter wrap:** the beat counter never wraps, because the segment ends at `cfg_count`-1.

## Structure

- **Package `axis_decimator_scheduler_pkg`:** the state encoding (IDLE=0, LOAD=1, RUN=2, 2 bits) and the default LOAD_CYCLES.
- **Segment-table slicing:** a generate-indexed mux inside the module.
- **Sub-module:** none is natural; the block is a single FSM plus two counters. It is instantiated alongside an unmodified `axis_decimator`.

## Test plan

- **Single segment:** NSEG=4, cfg_nseg=1, ratio=3, count=5, constant source, tready=1.
  - LOAD lasts 2 cycles.
  - 5 beats, one per 4 input samples; tlast on beat 5, tuser=0.
  - `sts_done` pulses once, then IDLE.
- **Three segments:** ratios 0/1/7, counts 4/2/3.
  - 9 beats; tlast on beats 4, 6 and 9; tuser 0,0,0,0,1,1,2,2,2.
  - `dec_cfg_data` 0→1→7; `dec_aresetn` low for 2 cycles before each segment.
- **Loop with random tready:** cfg_loop=1, 2 segments with counts 3/3, random 50 % tready.
  - tlast every 3rd beat; tuser alternates per segment.
  - No handshake lost or duplicated over 100 beats; `sts_done` never asserted.
- **Abort:** `cfg_enable` dropped mid-segment 1, beat 2.
  - IDLE next cycle; `dec_aresetn`=0, tvalid=0, no `sts_done`.
  - Re-enabling restarts at segment 0 with the beat counter at 0.
- **Zero count:** count[1]=0 with cfg_nseg=3.
  - Segment 1 emits no beats; it costs exactly LOAD_CYCLES.
  - Segment 2 is tagged tuser=2.
- **Reset mid-RUN:** `aresetn` low for 1 cycle.
  - All outputs take their reset values.
  - The block stays IDLE until a new `cfg_enable` rising edge.

Source files
------------

// File: rtl/axis_decimator_scheduler_pkg.sv
// Shared definitions for the decimator segment scheduler: FSM state
// encoding and the default decimator reset hold time per segment load.
package axis_decimator_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  // Cycles the decimator is held in reset while a segment ratio is loaded
  localparam int DEF_LOAD_CYCLES = 2;

endpackage : axis_decimator_scheduler_pkg

// File: rtl/axis_decimator_scheduler_if.sv
// AXI4-Stream beat bundle used on both sides of the scheduler.
// The master modport drives a stream, the slave modport consumes one.
interface axis_decimator_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 2
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface : axis_decimator_scheduler_if

// File: rtl/axis_decimator_scheduler.sv
// Segment scheduler for an axis_decimator. Walks a table of up to NSEG
// segments, loading each segment's ratio into the decimator under reset,
// then passing the decimator stream through while counting output beats.
// The last beat of each segment carries tlast; every beat carries the
// segment index in tuser.
module axis_decimator_scheduler
  import axis_decimator_scheduler_pkg::*;
#(
  parameter int CNTR_WIDTH       = 32,
  parameter int SMPL_WIDTH       = 32,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int NSEG             = 4,
  parameter int LOAD_CYCLES      = DEF_LOAD_CYCLES
) (
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic                          cfg_enable,
  input  logic                          cfg_loop,
  input  logic [$clog2(NSEG):0]         cfg_nseg,
  input  logic [NSEG*CNTR_WIDTH-1:0]    cfg_ratio,
  input  logic [NSEG*SMPL_WIDTH-1:0]    cfg_count,

  output logic                          dec_aresetn,
  output logic [CNTR_WIDTH-1:0]         dec_cfg_data,

  axis_decimator_scheduler_if.slave     s_axis,
  axis_decimator_scheduler_if.master    m_axis,

  output logic                          sts_busy,
  output logic [$clog2(NSEG)-1:0]       sts_segment,
  output logic                          sts_done
);

  localparam int SEG_W  = $clog2(NSEG);
  localparam int NSEG_W = $clog2(NSEG) + 1;
  localparam int LC_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [NSEG_W-1:0] NSEG_MAX  = NSEG_W'(NSEG);
  localparam logic [LC_W-1:0]   LOAD_LAST = LC_W'(LOAD_CYCLES - 1);

  // Sequencer state
  sched_state_t          state_r;
  logic [SEG_W-1:0]      seg_r;
  logic [LC_W-1:0]       load_cnt_r;
  logic [SMPL_WIDTH-1:0] beat_cnt_r;
  logic                  en_prev_r;
  logic                  dec_aresetn_r;
  logic [CNTR_WIDTH-1:0] dec_cfg_data_r;
  logic                  done_r;

  // Decoded per-segment configuration
  logic [CNTR_WIDTH-1:0] ratio_tab_s [NSEG];
  logic [SMPL_WIDTH-1:0] count_tab_s [NSEG];
  logic [SMPL_WIDTH-1:0] cur_count_s;
  logic [NSEG_W-1:0]     nseg_eff_s;

  // Control decode
  logic                  run_s;
  logic                  hs_s;
  logic                  tlast_s;
  logic                  load_done_s;
  logic                  seg_end_s;
  logic [SEG_W-1:0]      next_seg_s;
  logic                  finish_s;
  logic                  unused_s;

  // Slice the packed segment tables into one entry per segment
  for (genvar k = 0; k < NSEG; k++) begin : g_tab
    assign ratio_tab_s[k] = cfg_ratio[k*CNTR_WIDTH +: CNTR_WIDTH];
    assign count_tab_s[k] = cfg_count[k*SMPL_WIDTH +: SMPL_WIDTH];
  end

  // Segment counts above the table size are clamped to the table size
  assign nseg_eff_s  = (cfg_nseg > NSEG_MAX) ? NSEG_MAX : cfg_nseg;
  assign cur_count_s = count_tab_s[seg_r];

  assign run_s       = (state_r == ST_RUN);
  assign hs_s        = run_s & s_axis.tvalid & m_axis.tready;
  // Counter stops at count-1, so it never needs to wrap
  assign tlast_s     = run_s & (beat_cnt_r == (cur_count_s - SMPL_WIDTH'(1)));
  assign load_done_s = (state_r == ST_LOAD) & (load_cnt_r == LOAD_LAST);
  // A segment ends on its tlast handshake, or right after its load when it
  // has no beats to deliver
  assign seg_end_s   = (hs_s & tlast_s) | (load_done_s & (cur_count_s == '0));

  // Choose the follow-on segment: next entry, wrap when looping, else finish
  always_comb begin
    next_seg_s = '0;
    finish_s   = 1'b0;
    if (({1'b0, seg_r} + NSEG_W'(1)) < nseg_eff_s) begin
      next_seg_s = seg_r + SEG_W'(1);
    end else if (cfg_loop) begin
      next_seg_s = '0;
    end else begin
      finish_s = 1'b1;
    end
  end

  // Sequencer FSM: state, segment index, counters and decimator controls
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r        <= ST_IDLE;
      seg_r          <= '0;
      load_cnt_r     <= '0;
      beat_cnt_r     <= '0;
      en_prev_r      <= 1'b0;
      dec_aresetn_r  <= 1'b0;
      dec_cfg_data_r <= '0;
      done_r         <= 1'b0;
    end else begin
      en_prev_r <= cfg_enable;
      done_r    <= 1'b0;
      if (!cfg_enable) begin
        // Abort: back to idle silently, decimator held in reset
        state_r       <= ST_IDLE;
        seg_r         <= '0;
        load_cnt_r    <= '0;
        beat_cnt_r    <= '0;
        dec_aresetn_r <= 1'b0;
      end else if (seg_end_s) begin
        load_cnt_r    <= '0;
        beat_cnt_r    <= '0;
        dec_aresetn_r <= 1'b0;
        if (finish_s) begin
          state_r <= ST_IDLE;
          seg_r   <= '0;
          done_r  <= 1'b1;
        end else begin
          state_r        <= ST_LOAD;
          seg_r          <= next_seg_s;
          dec_cfg_data_r <= ratio_tab_s[next_seg_s];
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (!en_prev_r && (cfg_nseg != '0)) begin
              state_r        <= ST_LOAD;
              seg_r          <= '0;
              load_cnt_r     <= '0;
              beat_cnt_r     <= '0;
              dec_aresetn_r  <= 1'b0;
              dec_cfg_data_r <= ratio_tab_s[0];
            end
          end
          ST_LOAD: begin
            if (load_done_s) begin
              load_cnt_r    <= '0;
              state_r       <= ST_RUN;
              dec_aresetn_r <= 1'b1;
            end else begin
              load_cnt_r <= load_cnt_r + LC_W'(1);
            end
          end
          ST_RUN: begin
            if (hs_s) begin
              beat_cnt_r <= beat_cnt_r + SMPL_WIDTH'(1);
            end
          end
          default: begin
            state_r       <= ST_IDLE;
            seg_r         <= '0;
            load_cnt_r    <= '0;
            beat_cnt_r    <= '0;
            dec_aresetn_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Zero-latency stream path, closed outside RUN
  assign m_axis.tvalid = run_s & s_axis.tvalid;
  assign s_axis.tready = run_s & m_axis.tready;
  assign m_axis.tdata  = run_s ? s_axis.tdata : '0;
  assign m_axis.tlast  = tlast_s;
  assign m_axis.tuser  = run_s ? seg_r : '0;

  // The decimator never drives sideband signals of its own
  assign unused_s = s_axis.tlast ^ (^s_axis.tuser);

  assign dec_aresetn  = dec_aresetn_r;
  assign dec_cfg_data = dec_cfg_data_r;
  assign sts_busy     = (state_r != ST_IDLE);
  assign sts_segment  = seg_r;
  assign sts_done     = done_r;

endmodule : axis_decimator_scheduler

// File: tb/tb_axis_decimator_scheduler.sv
// Bench for axis_decimator_scheduler. The bench plays the decimator (one
// output per ratio+1 cycles while out of reset) and the downstream sink.
// Expected beats, segment starts and reset-hold lengths come from a table
// model built straight from the segment configuration.
module tb_axis_decimator_scheduler;
  import axis_decimator_scheduler_pkg::*;

  localparam int CW     = 32;
  localparam int SW     = 32;
  localparam int DW     = 32;
  localparam int NSEG   = 4;
  localparam int LC     = DEF_LOAD_CYCLES;
  localparam int SEG_W  = $clog2(NSEG);
  localparam int NSEG_W = $clog2(NSEG) + 1;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 cfg_enable;
  logic                 cfg_loop;
  logic [NSEG_W-1:0]    cfg_nseg;
  logic [NSEG*CW-1:0]   cfg_ratio;
  logic [NSEG*SW-1:0]   cfg_count;
  logic                 dec_aresetn;
  logic [CW-1:0]        dec_cfg_data;
  logic                 sts_busy;
  logic [SEG_W-1:0]     sts_segment;
  logic                 sts_done;

  axis_decimator_scheduler_if #(.DATA_W(DW), .USER_W(SEG_W)) s_if ();
  axis_decimator_scheduler_if #(.DATA_W(DW), .USER_W(SEG_W)) m_if ();

  axis_decimator_scheduler #(
    .CNTR_WIDTH(CW), .SMPL_WIDTH(SW), .AXIS_TDATA_WIDTH(DW),
    .NSEG(NSEG), .LOAD_CYCLES(LC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_enable(cfg_enable), .cfg_loop(cfg_loop), .cfg_nseg(cfg_nseg),
    .cfg_ratio(cfg_ratio), .cfg_count(cfg_count),
    .dec_aresetn(dec_aresetn), .dec_cfg_data(dec_cfg_data),
    .s_axis(s_if), .m_axis(m_if),
    .sts_busy(sts_busy), .sts_segment(sts_segment), .sts_done(sts_done)
  );

  // 100 MHz clock
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned ratio_a [NSEG];
  int unsigned count_a [NSEG];
  int          beat_q [$];
  int          run_q  [$];
  int          low_q  [$];
  bit          armed, exp_done, dec_prev, last_hs, src_valid;
  logic [DW-1:0] src_data;
  int          low_cnt, beats_seen, done_seen, gap, valid_pct, rdy_pct;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_cfg(input int nseg, input bit loop);
    cfg_nseg = NSEG_W'(nseg);
    cfg_loop = loop;
    for (int k = 0; k < NSEG; k++) begin
      cfg_ratio[k*CW +: CW] = CW'(ratio_a[k]);
      cfg_count[k*SW +: SW] = SW'(count_a[k]);
    end
  endtask

  // Expected beat list, segment starts and reset-hold lengths for 'rounds' passes
  task automatic arm(input int rounds);
    int n, skipped, cnt;
    n = (int'(cfg_nseg) > NSEG) ? NSEG : int'(cfg_nseg);
    beat_q.delete(); run_q.delete(); low_q.delete();
    skipped = 0;
    for (int r = 0; r < rounds; r++) begin
      for (int s = 0; s < n; s++) begin
        cnt = int'(count_a[s]);
        if (cnt == 0) begin
          skipped++;
        end else begin
          run_q.push_back(s);
          low_q.push_back(LC * (skipped + 1));
          skipped = 0;
          for (int b = 0; b < cnt; b++) beat_q.push_back(s * 2 + ((b == cnt - 1) ? 1 : 0));
        end
      end
    end
    low_cnt = 0; beats_seen = 0; done_seen = 0; exp_done = 1'b0; armed = 1'b1;
  endtask

  task automatic monitor();
    bit hs;
    int e, s, l;
    hs = m_if.tvalid && m_if.tready;
    if (!dec_aresetn) check_eq("gate_outside_run", 64'({m_if.tvalid, s_if.tready}), 64'(2'b00));
    if (sts_done || exp_done) begin
      check_eq("sts_done", 64'(sts_done), 64'(exp_done));
      if (exp_done) check_eq("done_with_idle", 64'(sts_busy), 64'(0));
    end
    if (sts_done) done_seen++;
    exp_done = 1'b0;
    if (armed) begin
      if (sts_busy && !dec_aresetn) low_cnt++;
      if (dec_aresetn && !dec_prev) begin
        check_eq("run_expected", 64'(run_q.size() != 0), 64'(1));
        if (run_q.size() != 0) begin
          s = run_q.pop_front();
          l = low_q.pop_front();
          check_eq("seg_ratio", 64'(dec_cfg_data), 64'(ratio_a[s]));
          check_eq("seg_index", 64'(sts_segment), 64'(s));
          check_eq("load_hold", 64'(low_cnt), 64'(l));
        end
        low_cnt = 0;
      end
      if (hs) begin
        beats_seen++;
        check_eq("beat_expected", 64'(beat_q.size() != 0), 64'(1));
        check_eq("tdata", 64'(m_if.tdata), 64'(src_data));
        if (beat_q.size() != 0) begin
          e = beat_q.pop_front();
          check_eq("tuser", 64'(m_if.tuser), 64'(e / 2));
          check_eq("tlast", 64'(m_if.tlast), 64'(e % 2));
          if (beat_q.size() == 0 && !cfg_loop) exp_done = 1'b1;
        end
      end
    end
    last_hs  = hs;
    dec_prev = dec_aresetn;
  endtask

  // Decimator stand-in: one beat per ratio+1 cycles, held until accepted
  task automatic drive_src();
    if (!dec_aresetn) begin
      src_valid = 1'b0;
      gap = 0;
    end else begin
      if (src_valid && last_hs) src_valid = 1'b0;
      if (!src_valid) begin
        if (gap >= int'(dec_cfg_data) && $urandom_range(0, 99) < valid_pct) begin
          src_valid = 1'b1;
          src_data  = $urandom();
          gap = 0;
        end else begin
          gap++;
        end
      end
    end
    s_if.tvalid = src_valid;
    s_if.tdata  = src_data;
    m_if.tready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic tick();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    drive_src();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_dec_aresetn"}, 64'(dec_aresetn), 64'(0));
    check_eq({tag, "_dec_cfg"}, 64'(dec_cfg_data), 64'(0));
    check_eq({tag, "_stream"}, 64'({m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready}), 64'(0));
    check_eq({tag, "_sts"}, 64'({sts_busy, sts_segment, sts_done}), 64'(0));
  endtask

  task automatic start_seq(input int rounds);
    arm(rounds);
    cfg_enable = 1'b1;
    tick();
    check_eq("start_busy", 64'(sts_busy), 64'(1));
    check_eq("start_dec_rst", 64'(dec_aresetn), 64'(0));
  endtask

  task automatic stop_seq();
    cfg_enable = 1'b0;
    armed = 1'b0;
    tick();
  endtask

  task automatic run_to_done(input string tag, input int maxc);
    int c;
    c = 0;
    while ((beat_q.size() != 0 || sts_busy) && c < maxc) begin
      tick();
      c++;
    end
    tick();
    check_eq({tag, "_beats_left"}, 64'(beat_q.size()), 64'(0));
    check_eq({tag, "_runs_left"}, 64'(run_q.size()), 64'(0));
    check_eq({tag, "_done_cnt"}, 64'(done_seen), 64'(1));
    check_eq({tag, "_idle"}, 64'(sts_busy), 64'(0));
  endtask

  task automatic run_beats(input int n, input int maxc);
    int c;
    c = 0;
    while (beats_seen < n && c < maxc) begin
      tick();
      c++;
    end
    check_eq("beats_reached", 64'(beats_seen), 64'(n));
  endtask

  task automatic abort_check(input string tag);
    rdy_pct = 0;
    m_if.tready = 1'b0;
    cfg_enable = 1'b0;
    armed = 1'b0;
    tick();
    check_eq({tag, "_idle"}, 64'(sts_busy), 64'(0));
    check_eq({tag, "_dec_rst"}, 64'(dec_aresetn), 64'(0));
    check_eq({tag, "_tvalid"}, 64'(m_if.tvalid), 64'(0));
    check_eq({tag, "_seg"}, 64'(sts_segment), 64'(0));
    tick();
    tick();
    check_eq({tag, "_no_done"}, 64'(done_seen), 64'(0));
  endtask

  initial begin
    aresetn = 1'b0; cfg_enable = 1'b0; cfg_loop = 1'b0; cfg_nseg = '0;
    cfg_ratio = '0; cfg_count = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    m_if.tready = 1'b0;
    armed = 1'b0; exp_done = 1'b0; dec_prev = 1'b0; last_hs = 1'b0; src_valid = 1'b0;
    src_data = '0; low_cnt = 0; beats_seen = 0; done_seen = 0; gap = 0;
    valid_pct = 100; rdy_pct = 100;

    // Single segment, enable held high through reset
    ratio_a = '{3, 0, 0, 0}; count_a = '{5, 1, 1, 1};
    apply_cfg(1, 1'b0);
    cfg_enable = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    arm(1);
    aresetn = 1'b1;
    tick();
    check_eq("rel_start_busy", 64'(sts_busy), 64'(1));
    check_eq("rel_load1", 64'(dec_aresetn), 64'(0));
    tick();
    check_eq("rel_load2", 64'(dec_aresetn), 64'(0));
    tick();
    check_eq("rel_run", 64'(dec_aresetn), 64'(1));
    check_eq("rel_ratio", 64'(dec_cfg_data), 64'(3));
    run_to_done("single", 200);
    stop_seq();

    // Three segments with distinct ratios
    ratio_a = '{0, 1, 7, 0}; count_a = '{4, 2, 3, 0};
    apply_cfg(3, 1'b0);
    start_seq(1);
    run_to_done("three", 400);
    stop_seq();

    // Zero-count middle segment
    ratio_a = '{1, 5, 2, 0}; count_a = '{2, 0, 3, 0};
    apply_cfg(3, 1'b0);
    start_seq(1);
    run_to_done("zero", 400);
    stop_seq();

    // Segment count above table size, random ratios and backpressure
    for (int k = 0; k < NSEG; k++) ratio_a[k] = $urandom_range(0, 3);
    count_a = '{1, 2, 1, 2};
    apply_cfg(7, 1'b0);
    rdy_pct = 60; valid_pct = 80;
    start_seq(1);
    run_to_done("clamp", 600);
    stop_seq();

    // Looping over two segments with random ready, then abort
    for (int k = 0; k < NSEG; k++) ratio_a[k] = $urandom_range(0, 2);
    count_a = '{3, 3, 0, 0};
    apply_cfg(2, 1'b1);
    rdy_pct = 50; valid_pct = 70;
    start_seq(40);
    run_beats(100, 4000);
    abort_check("loop_abort");
    cfg_loop = 1'b0;

    // Abort in segment 1 at beat 2, then restart from segment 0
    ratio_a = '{0, 0, 0, 0}; count_a = '{4, 4, 4, 0};
    apply_cfg(3, 1'b0);
    rdy_pct = 100; valid_pct = 100;
    start_seq(1);
    run_beats(6, 200);
    abort_check("mid_abort");
    rdy_pct = 100;
    start_seq(1);
    run_to_done("reenable", 400);
    stop_seq();

    // Reset pulse during RUN
    ratio_a = '{1, 0, 0, 0}; count_a = '{5, 0, 0, 0};
    apply_cfg(1, 1'b0);
    start_seq(1);
    run_beats(2, 200);
    aresetn = 1'b0;
    cfg_enable = 1'b0;
    armed = 1'b0;
    tick();
    check_reset("mid_rst");
    aresetn = 1'b1;
    repeat (3) tick();
    check_eq("rst_stays_idle", 64'(sts_busy), 64'(0));
    start_seq(1);
    run_to_done("after_rst", 200);
    stop_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_axis_decimator_scheduler
